gpio_ctrl: RTL and testbench

- Slow-clock GPIO peripheral on the low-frequency side of the CPU's high-to-low bus adapter.
- Consumes the adapter's single-cycle read/write strobes, address and write data on the slow clock.
- Returns registered, held read data.
- Provides direction/output/input registers, 2-flop input synchronisation, per-pin edge detection and a level interrupt.

---
 rtl/gpio_pkg.sv | 23 ++
 rtl/gpio_in_sync.sv | 85 ++++++++
 rtl/gpio_ctrl.sv | 143 ++++++++++++++
 tb/tb_gpio_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - GPIO controller constants; address width set by `MAX_BIT_POS (default 31)
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

package gpio_pkg;

  // Low bit of the block-select compare; each block spans 32 bytes
  localparam int GPIO_ADDR_MATCH_LSB = 5;

  // Width of the word-register index taken from l_addr[4:2]
  localparam int GPIO_REG_IDX_W = 3;

  typedef logic [GPIO_REG_IDX_W-1:0] gpio_reg_idx_t;

  localparam gpio_reg_idx_t GPIO_OFF_DIR = 3'd0;
  localparam gpio_reg_idx_t GPIO_OFF_OUT = 3'd1;
  localparam gpio_reg_idx_t GPIO_OFF_IN  = 3'd2;
  localparam gpio_reg_idx_t GPIO_OFF_IE  = 3'd3;
  localparam gpio_reg_idx_t GPIO_OFF_IS  = 3'd4;
  localparam gpio_reg_idx_t GPIO_OFF_POL = 3'd5;

endpackage

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - pad synchroniser, optional debounce (GPIO_DEBOUNCE_EN), edge detect
module gpio_in_sync #(
  parameter int GPIO_WIDTH = 16
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_DIV = 1000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  input  logic [GPIO_WIDTH-1:0] pol_i,
  output logic [GPIO_WIDTH-1:0] level_o,
  output logic [GPIO_WIDTH-1:0] edge_o
);

  logic [GPIO_WIDTH-1:0] meta_q;
  logic [GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] lvl;

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tick;
  logic [GPIO_WIDTH-1:0] h0_q, h0_d;
  logic [GPIO_WIDTH-1:0] h1_q, h1_d;
  logic [GPIO_WIDTH-1:0] h2_q, h2_d;
  logic [GPIO_WIDTH-1:0] db_q, db_d;

  // Prescaler tick, 3-deep sample history and agree-all-three debounced level
  always_comb begin
    tick  = (cnt_q == CNT_W'(DEBOUNCE_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    h0_d  = h0_q;
    h1_d  = h1_q;
    h2_d  = h2_q;
    if (tick) begin
      h0_d = sync_q;
      h1_d = h0_q;
      h2_d = h1_q;
    end
    // All ones forces 1, all zeros forces 0, anything mixed keeps the old level
    db_d = (h0_q & h1_q & h2_q) | (db_q & (h0_q | h1_q | h2_q));
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      h0_q  <= '0;
      h1_q  <= '0;
      h2_q  <= '0;
      db_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      h0_q  <= h0_d;
      h1_q  <= h1_d;
      h2_q  <= h2_d;
      db_q  <= db_d;
    end
  end

  assign lvl = db_q;
`else
  assign lvl = sync_q;
`endif

  // Two-flop synchroniser plus one cycle of level history for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= gpio_i;
      sync_q <= meta_q;
      prev_q <= lvl;
    end
  end

  assign level_o = lvl;
  assign edge_o  = (pol_i & lvl & ~prev_q) | (~pol_i & ~lvl & prev_q);

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - slow-clock GPIO register block; GPIO_DEBOUNCE_EN enables input debounce
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          GPIO_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0100
`ifdef GPIO_DEBOUNCE_EN
  , parameter int        DEBOUNCE_DIV = 1000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  l_read_en,
  input  logic                  l_write_en,
  input  logic [`MAX_BIT_POS:0] l_addr,
  input  logic [WIDTH-1:0]      l_data_in,
  output logic [WIDTH-1:0]      l_data_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] ie_q,  ie_d;
  logic [GPIO_WIDTH-1:0] is_q,  is_d;
  logic [GPIO_WIDTH-1:0] pol_q, pol_d;
  logic                  irq_q, irq_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;

  logic                  hit;
  logic                  wr_hit;
  logic                  rd_stb;
  gpio_reg_idx_t         idx;
  logic [GPIO_WIDTH-1:0] wdata;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic [GPIO_WIDTH-1:0] rd_val;
  logic [GPIO_WIDTH-1:0] pin_level;
  logic [GPIO_WIDTH-1:0] pin_edge;

  gpio_in_sync #(
    .GPIO_WIDTH  (GPIO_WIDTH)
`ifdef GPIO_DEBOUNCE_EN
    , .DEBOUNCE_DIV(DEBOUNCE_DIV)
`endif
  ) u_in_sync (
    .clk     (clk),
    .rst     (rst),
    .gpio_i  (gpio_in),
    .pol_i   (pol_q),
    .level_o (pin_level),
    .edge_o  (pin_edge)
  );

  assign hit    = (l_addr[`MAX_BIT_POS:GPIO_ADDR_MATCH_LSB] ==
                   BASE_ADDR[`MAX_BIT_POS:GPIO_ADDR_MATCH_LSB]);
  assign idx    = l_addr[GPIO_ADDR_MATCH_LSB-1:2];
  assign wr_hit = hit & l_write_en;
  // A simultaneous write strobe turns the access into a write-only cycle
  assign rd_stb = l_read_en & ~l_write_en;
  assign wdata  = l_data_in[GPIO_WIDTH-1:0];

  // Byte lane bits and data bits above the pin count carry no information here
  logic unused_bits;
  if (WIDTH > GPIO_WIDTH) begin : g_unused_hi
    assign unused_bits = ^{l_addr[1:0], l_data_in[WIDTH-1:GPIO_WIDTH]};
  end else begin : g_unused_lo
    assign unused_bits = ^l_addr[1:0];
  end

  // Read mux; unmapped offsets 6 and 7 read as zero
  always_comb begin
    rd_val = '0;
    case (idx)
      GPIO_OFF_DIR: rd_val = dir_q;
      GPIO_OFF_OUT: rd_val = out_q;
      GPIO_OFF_IN:  rd_val = pin_level;
      GPIO_OFF_IE:  rd_val = ie_q;
      GPIO_OFF_IS:  rd_val = is_q;
      GPIO_OFF_POL: rd_val = pol_q;
      default:      rd_val = '0;
    endcase
  end

  // Register writes, W1C status with set-wins, registered interrupt and held read data
  always_comb begin
    dir_d    = dir_q;
    out_d    = out_q;
    ie_d     = ie_q;
    pol_d    = pol_q;
    w1c_mask = '0;
    rdata_d  = rdata_q;
    if (wr_hit) begin
      case (idx)
        GPIO_OFF_DIR: dir_d    = wdata;
        GPIO_OFF_OUT: out_d    = wdata;
        GPIO_OFF_IE:  ie_d     = wdata;
        GPIO_OFF_IS:  w1c_mask = wdata;
        GPIO_OFF_POL: pol_d    = wdata;
        default:      ;
      endcase
    end
    // A new edge in the clearing cycle is ORed in after the clear, so it survives
    is_d  = (is_q & ~w1c_mask) | pin_edge;
    irq_d = |(is_q & ie_q);
    // Misses return zero so several slaves can be OR-combined upstream
    if (rd_stb) begin
      rdata_d = '0;
      if (hit) begin
        rdata_d[GPIO_WIDTH-1:0] = rd_val;
      end
    end
  end

  // Register state; reset drops any in-flight access
  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_q   <= '0;
      out_q   <= '0;
      ie_q    <= '0;
      is_q    <= '0;
      pol_q   <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      ie_q    <= ie_d;
      is_q    <= is_d;
      pol_q   <= pol_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign l_data_out = rdata_q;
  assign gpio_out   = out_q;
  assign gpio_oe    = dir_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - scoreboard testbench for gpio_ctrl
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module tb_gpio_ctrl;

  localparam int          WIDTH = 32;
  localparam int          GW    = 16;
  localparam logic [31:0] BASE  = 32'h1000_0100;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  l_read_en = 1'b0;
  logic                  l_write_en = 1'b0;
  logic [`MAX_BIT_POS:0] l_addr = '0;
  logic [WIDTH-1:0]      l_data_in = '0;
  logic [WIDTH-1:0]      l_data_out;
  logic [GW-1:0]         gpio_in = '0;
  logic [GW-1:0]         gpio_out;
  logic [GW-1:0]         gpio_oe;
  logic                  irq;

  always #5 clk = ~clk;

  gpio_ctrl #(
    .WIDTH      (WIDTH),
    .GPIO_WIDTH (GW),
    .BASE_ADDR  (BASE)
`ifdef GPIO_DEBOUNCE_EN
    , .DEBOUNCE_DIV(4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .l_read_en  (l_read_en),
    .l_write_en (l_write_en),
    .l_addr     (l_addr),
    .l_data_in  (l_data_in),
    .l_data_out (l_data_out),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [GW-1:0] m_dir = '0, m_out = '0, m_ie = '0, m_is = '0, m_pol = '0;
  logic          m_irq = 1'b0;
  // pin value seen at the previous 1, 2 and 3 clock edges
  logic [GW-1:0] pin1 = '0, pin2 = '0, pin3 = '0;
  logic [GW-1:0] db_level = '0, db_prev = '0;
  logic [31:0]   exp_q[$];
  bit            rd_evt = 0, rst_evt = 0, started = 0;

  always @(posedge clk) begin
    logic [GW-1:0] lvl, prv, edg, wd, nxt_is;
    logic [2:0]    off;
    logic [31:0]   rv;
    bit            hit;
    started = 1;
    rd_evt  = 0;
    rst_evt = 0;
    if (!rst) begin
      m_dir = '0; m_out = '0; m_ie = '0; m_is = '0; m_pol = '0; m_irq = 1'b0;
      pin1 = '0; pin2 = '0; pin3 = '0; db_prev = '0;
      rst_evt = 1;
    end else begin
`ifdef GPIO_DEBOUNCE_EN
      lvl = db_level;
      prv = db_prev;
`else
      lvl = pin2;
      prv = pin3;
`endif
      for (int i = 0; i < GW; i++) begin
        if (m_pol[i]) edg[i] = lvl[i] && !prv[i];
        else          edg[i] = !lvl[i] && prv[i];
      end
      hit = (l_addr[31:5] == BASE[31:5]);
      off = l_addr[4:2];
      wd  = l_data_in[GW-1:0];
      if (l_read_en && !l_write_en) begin
        rv = 32'h0;
        if (hit) begin
          case (off)
            3'd0: rv = {16'h0, m_dir};
            3'd1: rv = {16'h0, m_out};
            3'd2: rv = {16'h0, lvl};
            3'd3: rv = {16'h0, m_ie};
            3'd4: rv = {16'h0, m_is};
            3'd5: rv = {16'h0, m_pol};
            default: rv = 32'h0;
          endcase
        end
        exp_q.push_back(rv);
        rd_evt = 1;
      end
      nxt_is = m_is;
      if (hit && l_write_en && off == 3'd4) nxt_is = nxt_is & ~wd;
      nxt_is = nxt_is | edg;
      m_irq = |(m_is & m_ie);
      if (hit && l_write_en) begin
        case (off)
          3'd0: m_dir = wd;
          3'd1: m_out = wd;
          3'd3: m_ie  = wd;
          3'd5: m_pol = wd;
          default: ;
        endcase
      end
      m_is = nxt_is;
      pin3 = pin2; pin2 = pin1; pin1 = gpio_in;
      db_prev = db_level;
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] held = 32'h0;
  always @(negedge clk) begin
    if (started) begin
      if (rst_evt) held = 32'h0;
      if (rd_evt) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
        else held = exp_q.pop_front();
      end
      chk("l_data_out", l_data_out, held);
      chk("gpio_out", {16'h0, gpio_out}, {16'h0, m_out});
      chk("gpio_oe", {16'h0, gpio_oe}, {16'h0, m_dir});
      chk("irq", {31'h0, irq}, {31'h0, m_irq});
    end
  end

  // ---------------- driver ----------------
  task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    l_read_en = rd; l_write_en = wr; l_addr = a; l_data_in = d;
    @(posedge clk); #1;
    l_read_en = 1'b0; l_write_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_reg(input int off, input logic [31:0] d);
    op(1'b0, 1'b1, BASE + 32'(off), d);
  endtask

  task automatic rd_reg(input int off);
    op(1'b1, 1'b0, BASE + 32'(off), 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int          kind;
    logic [31:0] a, d;

    // reset with all pads high
    gpio_in = 16'hFFFF;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
    chk("rst_gpio_oe", {16'h0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_rdata", l_data_out, 32'h0);
    rst = 1'b1;
`ifdef GPIO_DEBOUNCE_EN
    idle(20);
    db_level = 16'hFFFF;
    idle(2);
`else
    idle(3);
`endif
    rd_reg(8);
    chk("in_after_reset", l_data_out, 32'h0000_FFFF);

`ifndef GPIO_DEBOUNCE_EN
    gpio_in = 16'h0000;
    idle(4);
`endif

    // write / readback
    wr_reg(0, 32'h0000_00FF);
    wr_reg(4, 32'hDEAD_BEEF);
    chk("oe_after_write", {16'h0, gpio_oe}, 32'h0000_00FF);
    chk("out_after_write", {16'h0, gpio_out}, 32'h0000_BEEF);
    rd_reg(4);
    chk("read_out", l_data_out, 32'h0000_BEEF);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("read_out_hold", l_data_out, 32'h0000_BEEF);
    end

    // miss and unmapped offsets
    op(1'b1, 1'b0, BASE + 32'h40, 32'h0);
    chk("read_miss", l_data_out, 32'h0);
    rd_reg(4);
    rd_reg(32'h18);
    chk("read_off18", l_data_out, 32'h0);
    wr_reg(32'h1C, 32'hFFFF_FFFF);
    chk("wr1c_out", {16'h0, gpio_out}, 32'h0000_BEEF);
    chk("wr1c_oe", {16'h0, gpio_oe}, 32'h0000_00FF);
    op(1'b1, 1'b1, BASE + 32'h4, 32'h0000_1234);
    chk("both_strobes_hold", l_data_out, 32'h0);
    chk("both_strobes_write", {16'h0, gpio_out}, 32'h0000_1234);

`ifndef GPIO_DEBOUNCE_EN
    // interrupt path
    wr_reg(32'h10, 32'hFFFF);
    wr_reg(32'h14, 32'h1);
    wr_reg(32'h0C, 32'h1);
    gpio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("irq_before", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("irq_set", {31'h0, irq}, 32'h1);
    @(negedge clk);
    wr_reg(32'h10, 32'h1);
    chk("irq_w1c_cycle", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1 chk("irq_cleared", {31'h0, irq}, 32'h0);
    @(negedge clk);
    gpio_in[0] = 1'b0;
    idle(6);
    chk("irq_fall_ignored", {31'h0, irq}, 32'h0);
    rd_reg(32'h10);
    chk("is_after_fall", l_data_out, 32'h0);

    // W1C in the same cycle as a new edge on bit 3
    wr_reg(32'h14, 32'h9);
    gpio_in[3] = 1'b1;
    idle(2);
    op(1'b0, 1'b1, BASE + 32'h10, 32'h8);
    rd_reg(32'h10);
    chk("w1c_race_is3", {31'h0, l_data_out[3]}, 32'h1);

    // mid-access reset drops the write
    rst = 1'b0;
    wr_reg(4, 32'h5555);
    rst = 1'b1;
    chk("reset_drops_write", {16'h0, gpio_out}, 32'h0);
`else
    // glitch shorter than three samples is rejected
    gpio_in[2] = 1'b0;
    idle(5);
    gpio_in[2] = 1'b1;
    idle(20);
    rd_reg(8);
    chk("glitch_in", l_data_out, 32'h0000_FFFF);
    rd_reg(32'h10);
    chk("glitch_is2", {31'h0, l_data_out[2]}, 32'h0);
    // a held level passes and sets the falling-edge status
    gpio_in[2] = 1'b0;
    idle(20);
    db_level[2] = 1'b0;
    idle(1);
    rd_reg(8);
    chk("held_in", l_data_out, 32'h0000_FFFB);
    rd_reg(32'h10);
    chk("held_is2", {31'h0, l_data_out[2]}, 32'h1);
`endif

    // randomized traffic against the model
    for (int it = 0; it < 600; it++) begin
      kind = $urandom_range(0, 9);
      a = BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) a = a ^ (32'h20 << $urandom_range(0, 26));
      d = $urandom;
`ifndef GPIO_DEBOUNCE_EN
      if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ (16'h1 << $urandom_range(0, 15));
      if (kind == 9 && $urandom_range(0, 7) == 0) begin
        rst = 1'b0;
        db_level = '0;
      end
`endif
      case (kind)
        0, 1, 2, 3: op(1'b1, 1'b0, a, d);
        4, 5, 6, 9: op(1'b0, 1'b1, a, d);
        7:          op(1'b1, 1'b1, a, d);
        default:    op(1'b0, 1'b0, a, d);
      endcase
      rst = 1'b1;
    end

    idle(3);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
